// File: rtl/magnitude_sqrt_scheduler.sv
// Shares one sqrt core across three colour channels: FIFO in, ch0..ch2 issue/wait, one reassembled pixel out.
// Optional MAGNITUDE_SCHED_SATURATE_EN clamps roots above 2^COLOR_CHANNEL-1; otherwise they wrap.
module magnitude_sqrt_scheduler #(
    parameter int COLOR_CHANNEL = 8,
    parameter int FIFO_DEPTH    = 4,
    localparam int SUM_W        = 2*COLOR_CHANNEL+1
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,
    input  logic                              i_data_ready,
    input  logic [2:0][SUM_W-1:0]             i_sum_of_squares,
    output logic                              o_in_ready,
    output logic                              o_overflow,
    output logic                              o_sqrt_start,
    output logic [SUM_W:0]                    o_sqrt_data,
    input  logic                              i_sqrt_done,
    input  logic [COLOR_CHANNEL:0]            i_sqrt_data,
    output logic                              o_data_ready,
    output logic [2:0][COLOR_CHANNEL-1:0]     o_magnitude_value,
    output logic                              o_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUTPUT} state_t;

    state_t                          state_q, state_d;
    logic [2:0][SUM_W-1:0]           fifo_q [FIFO_DEPTH];
    logic [AW-1:0]                   wr_ptr_q, rd_ptr_q;
    logic [AW:0]                     count_q;
    logic                            overflow_q;
    logic [2:0][SUM_W-1:0]           work_q;
    logic [1:0]                      ch_q;
    logic [1:0][COLOR_CHANNEL-1:0]   result_q;
    logic [2:0][COLOR_CHANNEL-1:0]   mag_q;
    logic [COLOR_CHANNEL-1:0]        root_lim;
    logic                            full, empty, push, pop, capture;

    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign push    = i_data_ready && !full;
    assign pop     = (state_q == S_IDLE) && !empty;
    assign capture = (state_q == S_WAIT) && i_sqrt_done;

`ifdef MAGNITUDE_SCHED_SATURATE_EN
    assign root_lim = i_sqrt_data[COLOR_CHANNEL] ? '1 : i_sqrt_data[COLOR_CHANNEL-1:0];
`else
    logic unused_root_msb;
    assign unused_root_msb = i_sqrt_data[COLOR_CHANNEL];
    assign root_lim        = i_sqrt_data[COLOR_CHANNEL-1:0];
`endif

    // Storage array carries no reset; occupancy is governed by count/pointers alone.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= i_sum_of_squares;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
            if (i_data_ready && full) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!empty) state_d = S_ISSUE;
            S_ISSUE:  state_d = S_WAIT;
            S_WAIT:   if (i_sqrt_done) state_d = (ch_q == 2'd2) ? S_OUTPUT : S_ISSUE;
            S_OUTPUT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Channel results park in result_q; the final root goes straight into the output word.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            work_q   <= '0;
            ch_q     <= 2'd0;
            result_q <= '0;
            mag_q    <= '0;
        end else if (pop) begin
            work_q <= fifo_q[rd_ptr_q];
            ch_q   <= 2'd0;
        end else if (capture) begin
            if (ch_q == 2'd2) begin
                mag_q[0] <= result_q[0];
                mag_q[1] <= result_q[1];
                mag_q[2] <= root_lim;
            end else begin
                result_q[ch_q[0]] <= root_lim;
                ch_q              <= ch_q + 2'd1;
            end
        end
    end

    always_comb begin
        o_sqrt_start = (state_q == S_ISSUE);
        o_data_ready = (state_q == S_OUTPUT);
        o_sqrt_data  = '0;
        if (state_q == S_ISSUE || state_q == S_WAIT) begin
            o_sqrt_data = {1'b0, work_q[ch_q]};
        end
    end

    assign o_in_ready        = !full;
    assign o_overflow        = overflow_q;
    assign o_magnitude_value = mag_q;
    assign o_busy            = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_magnitude_sqrt_scheduler.sv
// Directed bench for magnitude_sqrt_scheduler with a mock sqrt core of programmable latency.
module tb_magnitude_sqrt_scheduler;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_data_ready = 1'b0;
    logic [2:0][16:0]  i_sum_of_squares = '0;
    logic              o_in_ready, o_overflow, o_sqrt_start, o_data_ready, o_busy;
    logic [17:0]       o_sqrt_data;
    logic              sqrt_done;
    logic [8:0]        mock_root = '0;
    logic [2:0][7:0]   o_magnitude_value;

    logic              mock_done = 1'b0;
    logic              force_done = 1'b0;
    int                lat = 1;
    int                pend = 0;
    logic [17:0]       op = '0;

    int                cyc = 0;
    int                errors = 0;
    int                checks = 0;
    int                start_cnt = 0;
    int                pulse_viol = 0;
    logic              prev_start = 1'b0, prev_dr = 1'b0;
    logic [23:0]       out_mag[$];
    int                out_cyc[$];

    assign sqrt_done = mock_done | force_done;

    magnitude_sqrt_scheduler dut (
        .i_clk             (clk),
        .i_reset_n         (rst_n),
        .i_data_ready      (i_data_ready),
        .i_sum_of_squares  (i_sum_of_squares),
        .o_in_ready        (o_in_ready),
        .o_overflow        (o_overflow),
        .o_sqrt_start      (o_sqrt_start),
        .o_sqrt_data       (o_sqrt_data),
        .i_sqrt_done       (sqrt_done),
        .i_sqrt_data       (mock_root),
        .o_data_ready      (o_data_ready),
        .o_magnitude_value (o_magnitude_value),
        .o_busy            (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r+1)*(r+1) <= x) r++;
        return r;
    endfunction

    function automatic logic [31:0] pack3(input int a0, input int a1, input int a2);
        logic [7:0] b0, b1, b2;
        b0 = 8'(a0); b1 = 8'(a1); b2 = 8'(a2);
        return {8'd0, b2, b1, b0};
    endfunction

    // Mock sqrt core: done arrives `lat` cycles after the start cycle.
    always @(negedge clk) begin
        mock_done = 1'b0;
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mock_done = 1'b1;
                    mock_root = 9'(isqrt(int'(op)));
                end
            end
            if (o_sqrt_start) begin
                op   = o_sqrt_data;
                pend = lat;
            end
        end
    end

    always @(negedge clk) begin
        if (o_data_ready) begin
            out_mag.push_back(o_magnitude_value);
            out_cyc.push_back(cyc);
        end
        if (o_sqrt_start) start_cnt++;
        if (o_sqrt_start && prev_start) pulse_viol++;
        if (o_data_ready && prev_dr) pulse_viol++;
        prev_start = o_sqrt_start;
        prev_dr    = o_data_ready;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_out(input int n, input int budget);
        int k = 0;
        while (out_mag.size() < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check("wait_out", out_mag.size(), n);
    endtask

    task automatic push_px(input int s0, input int s1, input int s2);
        int k = 0;
        while (!o_in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        i_data_ready        = 1'b1;
        i_sum_of_squares[0] = 17'(s0);
        i_sum_of_squares[1] = 17'(s1);
        i_sum_of_squares[2] = 17'(s2);
        @(negedge clk);
        i_data_ready = 1'b0;
    endtask

    int t0, sc, sat;
    int rt[8][3] = '{'{0,255,17}, '{1,2,3}, '{200,201,202}, '{12,34,56},
                     '{99,100,101}, '{7,0,250}, '{128,64,32}, '{15,16,15}};
    int gap[8] = '{0, 3, 1, 0, 5, 2, 0, 1};

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", o_in_ready, 1);
        check("rst_overflow", o_overflow, 0);
        check("rst_start", o_sqrt_start, 0);
        check("rst_sqrt_data", o_sqrt_data, 0);
        check("rst_data_ready", o_data_ready, 0);
        check("rst_mag", o_magnitude_value, 0);
        check("rst_busy", o_busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single pixel, L=1: {9,16,25} -> {3,4,5} at T+8
        lat = 1;
        out_mag.delete(); out_cyc.delete();
        t0 = cyc;
        i_data_ready = 1'b1;
        i_sum_of_squares[0] = 17'd9; i_sum_of_squares[1] = 17'd16; i_sum_of_squares[2] = 17'd25;
        @(negedge clk);
        i_data_ready = 1'b0;
        check("t1_busy_after_push", o_busy, 1);
        @(negedge clk);
        check("t1_issue_start", o_sqrt_start, 1);
        check("t1_issue_data", o_sqrt_data, 9);
        @(negedge clk);
        check("t1_wait_start", o_sqrt_start, 0);
        check("t1_wait_data_held", o_sqrt_data, 9);
        wait_out(1, 50);
        if (out_mag.size() >= 1) begin
            check("t1_latency", out_cyc[0] - t0, 8);
            check("t1_mag", out_mag[0], pack3(3, 4, 5));
        end
        repeat (2) @(negedge clk);
        check("t1_mag_hold", o_magnitude_value, pack3(3, 4, 5));
        check("t1_idle_busy", o_busy, 0);

        // Root above 255: clamp or wrap
        out_mag.delete(); out_cyc.delete();
`ifdef MAGNITUDE_SCHED_SATURATE_EN
        sat = 255;
`else
        sat = 104;
`endif
        push_px(130050, 130050, 130050);
        wait_out(1, 50);
        if (out_mag.size() >= 1) check("t2_range_limit", out_mag[0], pack3(sat, sat, sat));

        // Stale done in IDLE
        out_mag.delete(); out_cyc.delete();
        @(negedge clk);
        sc = start_cnt;
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        @(negedge clk);
        check("t3_idle_done_busy", o_busy, 0);
        check("t3_idle_done_start", start_cnt, sc);
        check("t3_idle_done_out", out_mag.size(), 0);

        // Stale done during OUTPUT
        t0 = cyc;
        i_data_ready = 1'b1;
        i_sum_of_squares[0] = 17'd1; i_sum_of_squares[1] = 17'd4; i_sum_of_squares[2] = 17'd9;
        @(negedge clk);
        i_data_ready = 1'b0;
        repeat (7) @(negedge clk);
        check("t3_output_cycle", o_data_ready, 1);
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        check("t3_after_output_busy", o_busy, 0);
        check("t3_after_output_start", o_sqrt_start, 0);
        repeat (5) @(negedge clk);
        check("t3_single_output", out_mag.size(), 1);
        if (out_mag.size() >= 1) check("t3_mag", out_mag[0], pack3(1, 2, 3));
        check("t3_start_count", start_cnt, sc + 3);

        // Overflow: six back-to-back pushes with L=3, sixth dropped
        lat = 3;
        out_mag.delete(); out_cyc.delete();
        for (int k = 0; k < 6; k++) begin
            if (k == 4) check("t4_in_ready_k4", o_in_ready, 1);
            if (k == 5) begin
                check("t4_in_ready_full", o_in_ready, 0);
                check("t4_overflow_before", o_overflow, 0);
            end
            i_data_ready = 1'b1;
            i_sum_of_squares[0] = 17'((k+1)*(k+1));
            i_sum_of_squares[1] = 17'((k+2)*(k+2));
            i_sum_of_squares[2] = 17'((k+3)*(k+3));
            @(negedge clk);
        end
        i_data_ready = 1'b0;
        check("t4_overflow_set", o_overflow, 1);
        wait_out(5, 200);
        repeat (20) @(negedge clk);
        check("t4_count", out_mag.size(), 5);
        for (int k = 0; k < 5 && k < out_mag.size(); k++)
            check($sformatf("t4_mag%0d", k), out_mag[k], pack3(k+1, k+2, k+3));
        for (int k = 1; k < 5 && k < out_cyc.size(); k++)
            check($sformatf("t4_spacing%0d", k), out_cyc[k] - out_cyc[k-1], 14);
        check("t4_overflow_sticky", o_overflow, 1);

        // Reset while waiting on ch1, then stale done and a new pixel
        out_mag.delete(); out_cyc.delete();
        i_data_ready = 1'b1;
        i_sum_of_squares[0] = 17'd100; i_sum_of_squares[1] = 17'd121; i_sum_of_squares[2] = 17'd144;
        @(negedge clk);
        i_data_ready = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_wait_ch1_data", o_sqrt_data, 121);
        check("t5_wait_ch1_start", o_sqrt_start, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_rst_busy", o_busy, 0);
        check("t5_rst_overflow", o_overflow, 0);
        check("t5_rst_mag", o_magnitude_value, 0);
        check("t5_rst_in_ready", o_in_ready, 1);
        rst_n = 1'b1;
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        @(negedge clk);
        check("t5_stale_busy", o_busy, 0);
        push_px(0, 1, 4);
        wait_out(1, 60);
        repeat (10) @(negedge clk);
        check("t5_out_count", out_mag.size(), 1);
        if (out_mag.size() >= 1) check("t5_mag", out_mag[0], pack3(0, 1, 2));
        check("t5_overflow", o_overflow, 0);

        // Streaming with L=2 and gaps
        lat = 2;
        out_mag.delete(); out_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            int s[3];
            repeat (gap[i]) @(negedge clk);
            for (int c = 0; c < 3; c++)
                s[c] = rt[i][c]*rt[i][c] + ((i*37 + c*11) % (2*rt[i][c] + 1));
            push_px(s[0], s[1], s[2]);
        end
        wait_out(8, 400);
        for (int i = 0; i < 8 && i < out_mag.size(); i++)
            check($sformatf("t6_mag%0d", i), out_mag[i], pack3(rt[i][0], rt[i][1], rt[i][2]));
        for (int i = 1; i < 8 && i < out_cyc.size(); i++)
            check($sformatf("t6_min_spacing%0d", i), 32'(out_cyc[i] - out_cyc[i-1] >= 11), 1);
        check("t6_overflow", o_overflow, 0);

        check("pulse_consecutive", pulse_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
